result_mux_arbiter: RTL and testbench

- Round-robin arbiter that shares one 3:1 32-bit select mux, and the downstream resource behind it, among three requesters (0: fetch, 1: load/store, 2: debug/aux).
- Grants one requester at a time and drives the mux select with that requester's index.
- Holds the grant until the resource signals completion.
- A hold-time watchdog forces release if completion never arrives.

---
 rtl/result_mux_arbiter.sv | 182 ++++++++++++++++++
 tb/tb_result_mux_arbiter.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/result_mux_arbiter.sv
// result_mux_arbiter
//   Round-robin arbiter for a shared 3:1 32-bit result mux and the resource
//   behind it. The requesters are 0 = fetch, 1 = load/store, 2 = debug/aux.
//   A grant stays in place until the resource reports done. If done does not
//   arrive, a hold-time watchdog forces the release.
//
// Parameters
//   MAX_HOLD  maximum cycles a grant may be held without done (2..255)
//   CNT_W     hold counter width, 2**CNT_W > MAX_HOLD
//
// Ports
//   clk       in   system clock, rising edge
//   rst_n     in   asynchronous active-low reset
//   req       in   [2:0] request vector, bit i = requester i
//   done      in   resource finished the current transaction (ignored when idle)
//   gnt       out  [2:0] one-hot grant, registered, zero when idle
//   sel       out  [1:0] mux select = granted index, registered, holds when idle
//   valid     out  grant active (== |gnt)
//   timeout   out  one-cycle pulse after a watchdog release
//   hold_cnt  out  [CNT_W-1:0] cycles elapsed in the current grant
module result_mux_arbiter #(
  parameter int MAX_HOLD = 16,
  parameter int CNT_W    = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [2:0]       req,
  input  logic             done,
  output logic [2:0]       gnt,
  output logic [1:0]       sel,
  output logic             valid,
  output logic             timeout,
  output logic [CNT_W-1:0] hold_cnt
);

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_e;

  state_e           state_q, state_d;
  logic [1:0]       ptr_q, ptr_d;
  logic [2:0]       gnt_q, gnt_d;
  logic [1:0]       sel_q, sel_d;
  logic             valid_q, valid_d;
  logic             timeout_q, timeout_d;
  logic [CNT_W-1:0] hold_cnt_q, hold_cnt_d;

  logic             hold_at_max_s;
  logic [1:0]       rel_ptr_s;
  logic [2:0]       arb_idle_s;
  logic [2:0]       arb_rel_s;

  // Round-robin search starting at p. Returns {found, index}.
  function automatic logic [2:0] arb(input logic [2:0] r, input logic [1:0] p);
    logic [1:0] c0, c1, c2;
    logic [2:0] res;
    case (p)
      2'd1:    begin c0 = 2'd1; c1 = 2'd2; c2 = 2'd0; end
      2'd2:    begin c0 = 2'd2; c1 = 2'd0; c2 = 2'd1; end
      default: begin c0 = 2'd0; c1 = 2'd1; c2 = 2'd2; end
    endcase
    if (r[c0]) begin
      res = {1'b1, c0};
    end else if (r[c1]) begin
      res = {1'b1, c1};
    end else if (r[c2]) begin
      res = {1'b1, c2};
    end else begin
      res = 3'b000;
    end
    return res;
  endfunction

  // Pointer value that follows winner w (mod 3).
  function automatic logic [1:0] next_ptr(input logic [1:0] w);
    logic [1:0] n;
    case (w)
      2'd0:    n = 2'd1;
      2'd1:    n = 2'd2;
      default: n = 2'd0;
    endcase
    return n;
  endfunction

  // Converts an index to a one-hot grant. Index 3 is never produced.
  function automatic logic [2:0] onehot(input logic [1:0] idx);
    logic [2:0] o;
    case (idx)
      2'd0:    o = 3'b001;
      2'd1:    o = 3'b010;
      2'd2:    o = 3'b100;
      default: o = 3'b000;
    endcase
    return o;
  endfunction

  // While BUSY, sel_q holds the current winner. Release therefore advances
  // the pointer past it and re-arbitrates on the same edge, so a new grant
  // follows with no idle cycle.
  assign hold_at_max_s = (hold_cnt_q == CNT_W'(MAX_HOLD - 1));
  assign rel_ptr_s     = next_ptr(sel_q);
  assign arb_idle_s    = arb(req, ptr_q);
  assign arb_rel_s     = arb(req, rel_ptr_s);

  // Next-state and next-output computation.
  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    gnt_d      = gnt_q;
    sel_d      = sel_q;
    valid_d    = valid_q;
    timeout_d  = 1'b0;
    hold_cnt_d = hold_cnt_q;
    case (state_q)
      IDLE: begin
        if (arb_idle_s[2]) begin
          state_d    = BUSY;
          gnt_d      = onehot(arb_idle_s[1:0]);
          sel_d      = arb_idle_s[1:0];
          valid_d    = 1'b1;
          hold_cnt_d = {CNT_W{1'b0}};
        end else begin
          state_d = IDLE;
        end
      end
      BUSY: begin
        if (done || hold_at_max_s) begin
          // When done arrives on the final hold cycle, it is a normal completion.
          timeout_d  = ~done;
          ptr_d      = rel_ptr_s;
          hold_cnt_d = {CNT_W{1'b0}};
          if (arb_rel_s[2]) begin
            gnt_d   = onehot(arb_rel_s[1:0]);
            sel_d   = arb_rel_s[1:0];
            valid_d = 1'b1;
          end else begin
            state_d = IDLE;
            gnt_d   = 3'b000;
            valid_d = 1'b0;
          end
        end else begin
          hold_cnt_d = hold_cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d    = IDLE;
        gnt_d      = 3'b000;
        valid_d    = 1'b0;
        hold_cnt_d = {CNT_W{1'b0}};
      end
    endcase
  end

  // State and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      ptr_q      <= 2'd0;
      gnt_q      <= 3'b000;
      sel_q      <= 2'b00;
      valid_q    <= 1'b0;
      timeout_q  <= 1'b0;
      hold_cnt_q <= {CNT_W{1'b0}};
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      gnt_q      <= gnt_d;
      sel_q      <= sel_d;
      valid_q    <= valid_d;
      timeout_q  <= timeout_d;
      hold_cnt_q <= hold_cnt_d;
    end
  end

  assign gnt      = gnt_q;
  assign sel      = sel_q;
  assign valid    = valid_q;
  assign timeout  = timeout_q;
  assign hold_cnt = hold_cnt_q;

endmodule

// File: tb/tb_result_mux_arbiter.sv
// Directed bench for result_mux_arbiter with MAX_HOLD = 4.
module tb_result_mux_arbiter;

  logic       clk;
  logic       rst_n;
  logic [2:0] req;
  logic       done;
  logic [2:0] gnt;
  logic [1:0] sel;
  logic       valid;
  logic       timeout;
  logic [7:0] hold_cnt;

  int n_cmp;
  int n_err;

  result_mux_arbiter #(.MAX_HOLD(4), .CNT_W(8)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .req      (req),
    .done     (done),
    .gnt      (gnt),
    .sel      (sel),
    .valid    (valid),
    .timeout  (timeout),
    .hold_cnt (hold_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [2:0] eg, input logic [1:0] es,
                     input logic ev, input logic et, input logic [7:0] eh);
    n_cmp++;
    assert (gnt === eg) else begin
      n_err++;
      $error("FAIL %s gnt: observed %b expected %b", tag, gnt, eg);
    end
    n_cmp++;
    assert (sel === es) else begin
      n_err++;
      $error("FAIL %s sel: observed %b expected %b", tag, sel, es);
    end
    n_cmp++;
    assert (valid === ev) else begin
      n_err++;
      $error("FAIL %s valid: observed %b expected %b", tag, valid, ev);
    end
    n_cmp++;
    assert (timeout === et) else begin
      n_err++;
      $error("FAIL %s timeout: observed %b expected %b", tag, timeout, et);
    end
    n_cmp++;
    assert (hold_cnt === eh) else begin
      n_err++;
      $error("FAIL %s hold_cnt: observed %0d expected %0d", tag, hold_cnt, eh);
    end
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    rst_n = 1'b0;
    req   = 3'b111;
    done  = 1'b0;

    // Reset is held while every requester asks.
    step();
    step();
    chk("reset_hold", 3'b000, 2'b00, 1'b0, 1'b0, 8'd0);
    rst_n = 1'b1;
    step();
    chk("rr_0", 3'b001, 2'b00, 1'b1, 1'b0, 8'd0);

    // Round-robin with done on every grant, and no idle gaps.
    done = 1'b1;
    step();
    chk("rr_1", 3'b010, 2'b01, 1'b1, 1'b0, 8'd0);
    step();
    chk("rr_2", 3'b100, 2'b10, 1'b1, 1'b0, 8'd0);
    step();
    chk("rr_3", 3'b001, 2'b00, 1'b1, 1'b0, 8'd0);
    req = 3'b000;
    step();
    chk("rr_drain", 3'b000, 2'b00, 1'b0, 1'b0, 8'd0);

    // done while idle is ignored. ptr is 1 at this point.
    step();
    chk("done_idle", 3'b000, 2'b00, 1'b0, 1'b0, 8'd0);
    done = 1'b0;

    // Single requester: the grant holds after req drops, and done releases it.
    req = 3'b010;
    step();
    chk("single_gnt", 3'b010, 2'b01, 1'b1, 1'b0, 8'd0);
    req = 3'b000;
    step();
    chk("single_h1", 3'b010, 2'b01, 1'b1, 1'b0, 8'd1);
    step();
    chk("single_h2", 3'b010, 2'b01, 1'b1, 1'b0, 8'd2);
    done = 1'b1;
    step();
    chk("single_rel", 3'b000, 2'b01, 1'b0, 1'b0, 8'd0);
    done = 1'b0;

    // Watchdog with no pending requester. ptr is 2, so req 001 wins.
    req = 3'b001;
    step();
    chk("wd_gnt", 3'b001, 2'b00, 1'b1, 1'b0, 8'd0);
    req = 3'b000;
    step();
    step();
    step();
    chk("wd_h3", 3'b001, 2'b00, 1'b1, 1'b0, 8'd3);
    step();
    chk("wd_release", 3'b000, 2'b00, 1'b0, 1'b1, 8'd0);
    step();
    chk("wd_pulse_end", 3'b000, 2'b00, 1'b0, 1'b0, 8'd0);

    // Watchdog with requester 2 pending. ptr is 1, so 001 wins first.
    req = 3'b001;
    step();
    chk("wd2_gnt", 3'b001, 2'b00, 1'b1, 1'b0, 8'd0);
    req = 3'b101;
    step();
    step();
    step();
    chk("wd2_h3", 3'b001, 2'b00, 1'b1, 1'b0, 8'd3);
    step();
    chk("wd2_handoff", 3'b100, 2'b10, 1'b1, 1'b1, 8'd0);

    // done arrives on the final hold cycle: normal release with no timeout.
    step();
    chk("bd_h1", 3'b100, 2'b10, 1'b1, 1'b0, 8'd1);
    step();
    step();
    chk("bd_h3", 3'b100, 2'b10, 1'b1, 1'b0, 8'd3);
    done = 1'b1;
    req  = 3'b000;
    step();
    chk("bd_done_last", 3'b000, 2'b10, 1'b0, 1'b0, 8'd0);
    done = 1'b0;

    // Async reset in the middle of a grant. ptr is 0 here.
    req = 3'b100;
    step();
    chk("ar_gnt", 3'b100, 2'b10, 1'b1, 1'b0, 8'd0);
    #3;
    rst_n = 1'b0;
    #1;
    chk("ar_clear", 3'b000, 2'b00, 1'b0, 1'b0, 8'd0);
    req = 3'b111;
    step();
    chk("ar_held", 3'b000, 2'b00, 1'b0, 1'b0, 8'd0);
    rst_n = 1'b1;
    step();
    chk("ar_restart", 3'b001, 2'b00, 1'b1, 1'b0, 8'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
